// File: rtl/mdu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : mdu_ctrl_pkg
// Description : Shared types and helpers for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mdu_ctrl_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  // State literals carry a prefix because MUL/DIV are already op names.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_signed_div(input mdu_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_core.sv
//------------------------------------------------------------------------------
// Module      : mdu_div_core
// Description : Unsigned restoring divider datapath, one quotient bit per step.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_div_core
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quot_q doubles as the dividend shift register; its MSB feeds the remainder.
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = shifted[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mdu_ctrl
// Description : RV32M multiply/divide sequencer for the EX stage; stalls the
//               pipeline while busy and pulses the result for one cycle.
//               MDU_DIV_EARLY_OUT_EN: finish |dividend| < |divisor| in one cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN    = MDU_XLEN,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall_mdu,
  output logic            res_valid,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] result
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_DIV_CNT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] C_MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [XLEN-1:0]  C_MIN     = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             spec_q, spec_d;
  logic [XLEN-1:0]  spec_res_q, spec_res_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       res_rd_q, res_rd_d;

  mdu_op_e          in_op;
  logic             in_signed, in_rem, early_out;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             div_load, div_step;
  logic [XLEN-1:0]  div_quot, div_rem;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]  mul_res, q_fix, r_fix, final_res;

  assign in_op     = mdu_op_e'(funct3);
  assign in_signed = op_is_signed_div(in_op);
  assign in_rem    = funct3[1];
  assign mag_a     = (in_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign mag_b     = (in_signed && op_b[XLEN-1]) ? -op_b : op_b;

`ifdef MDU_DIV_EARLY_OUT_EN
  assign early_out = (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Operands widened to 2*XLEN so the truncated product is exact for every variant.
  always_comb begin
    mul_a = {{XLEN{((op_q == MULH) || (op_q == MULHSU)) && a_q[XLEN-1]}}, a_q};
    mul_b = {{XLEN{(op_q == MULH) && b_q[XLEN-1]}}, b_q};
    prod  = mul_a * mul_b;
    mul_res = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    q_fix = (op_is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quot : div_quot;
    r_fix = (op_is_signed_div(op_q) && a_q[XLEN-1]) ? -div_rem : div_rem;
    if (!op_is_div(op_q))  final_res = mul_res;
    else if (spec_q)       final_res = spec_res_q;
    else if (op_q[1])      final_res = r_fix;
    else                   final_res = q_fix;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    res_rd_d   = res_rd_q;
    stall_mdu  = 1'b0;
    res_valid  = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          stall_mdu = 1'b1;
          op_d      = in_op;
          a_d       = op_a;
          b_d       = op_b;
          rd_d      = ex_rd;
          spec_d    = 1'b0;
          if (!funct3[2]) begin
            cnt_d   = C_MUL_CNT;
            state_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
          end else begin
            div_load = 1'b1;
            cnt_d    = C_DIV_CNT;
            state_d  = ST_DONE;
            spec_d   = 1'b1;
            if (op_b == '0)
              spec_res_d = in_rem ? op_a : '1;
            else if (in_signed && (op_a == C_MIN) && (op_b == '1))
              spec_res_d = in_rem ? '0 : C_MIN;
            else if (early_out)
              spec_res_d = in_rem ? op_a : '0;
            else begin
              spec_d  = 1'b0;
              state_d = ST_DIV;
            end
          end
        end
      end
      // The start cycle is the first multiply busy cycle, so leave when one remains.
      ST_MUL: begin
        stall_mdu = 1'b1;
        cnt_d     = cnt_q - C_ONE;
        if (cnt_q <= C_ONE) state_d = ST_DONE;
      end
      ST_DIV: begin
        stall_mdu = 1'b1;
        div_step  = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - C_ONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        result_d  = final_res;
        res_rd_d  = rd_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      stall_mdu = 1'b0;
      res_valid = 1'b0;
      div_step  = 1'b0;
      result_d  = result_q;
      res_rd_d  = res_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= MUL;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      res_rd_q   <= res_rd_d;
    end
  end

  assign result = res_valid ? final_res : result_q;
  assign res_rd = res_valid ? rd_q : res_rd_q;

endmodule

`default_nettype wire
